// File: rtl/smvm_stream_if.sv
// Stream bundle for smvm_stream: one framed input stream and one result stream.
// Handshake: a beat transfers on a rising edge where valid&ready; ready is
// driven only from registered state, and valid/payload stay stable until taken.
interface smvm_stream_if #(
  parameter int VW = 8,
  parameter int CW = 7,
  parameter int AW = 2*VW + CW
);
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic [CW-1:0] in_col;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;

  modport master (
    output in_valid, in_data, in_col, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_col, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/smvm_stream.sv
// Streaming sparse matrix x dense vector: header, vector beats, then nonzeros
// grouped K at a time; per-row dot products leave through an output FIFO.
module smvm_stream #(
  parameter int K     = 4,
  parameter int VW    = 8,
  parameter int CW    = 7,
  parameter int DEPTH = 2*K
)(
  input  logic         clk,
  input  logic         rst_n,
  smvm_stream_if.slave bus,
  output logic         busy,
  output logic [1:0]   o_dbg_state
);
  localparam int AW   = 2*VW + CW;
  localparam int MAXC = 1 << CW;
  localparam int PW   = 2*VW;
  localparam int GW   = $clog2(K);
  localparam int NW   = $clog2(K+1);
  localparam int FW   = $clog2(DEPTH+1);
  localparam int DW   = $clog2(DEPTH);
  localparam int IW   = $clog2(2*DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_VEC = 2'd1, S_MAT = 2'd2, S_DRAIN = 2'd3} state_t;

  function automatic logic [DW-1:0] wrap(input logic [IW-1:0] x);
    if (x >= IW'(DEPTH)) return DW'(x - IW'(DEPTH));
    else                 return DW'(x);
  endfunction

  state_t                 r_state;
  logic [VW-1:0]          r_rows;
  logic [VW-1:0]          r_done;
  logic [CW:0]            r_cols;
  logic [CW:0]            r_vidx;
  logic [VW-1:0]          r_vec [MAXC];
  logic [MAXC-1:0]        r_vvalid;
  logic [VW-1:0]          r_g_data [K];
  logic [CW-1:0]          r_g_col [K];
  logic [K-1:0]           r_g_last;
  logic [GW-1:0]          r_g_cnt;
  logic                   r_p_valid;
  logic signed [PW-1:0]   r_p_prod [K];
  logic [K-1:0]           r_p_last;
  logic                   r_s_valid;
  logic signed [AW-1:0]   r_s_sum [K];
  logic [K-1:0]           r_s_last;
  logic signed [AW-1:0]   r_carry;
  logic signed [AW-1:0]   r_mem [DEPTH];
  logic [DW-1:0]          r_rd;
  logic [DW-1:0]          r_wr;
  logic [FW-1:0]          r_count;

  logic                   w_ready;
  logic                   w_acc;
  logic                   w_last_row;
  logic                   w_issue;
  logic                   w_pop;
  logic [VW-1:0]          w_ln_data [K];
  logic [CW-1:0]          w_ln_col [K];
  logic [K-1:0]           w_ln_last;
  logic [VW-1:0]          w_vv [K];
  logic signed [PW-1:0]   w_a [K];
  logic signed [PW-1:0]   w_b [K];
  logic signed [PW-1:0]   w_prod [K];
  logic [NW-1:0]          w_p_n;
  logic [NW-1:0]          w_s_n;
  logic [IW-1:0]          w_occ;
  logic signed [AW-1:0]   w_sum [K];
  logic signed [AW-1:0]   w_run;
  logic [DW-1:0]          w_widx [K];
  logic [IW-1:0]          w_off;

  assign w_acc      = bus.in_valid & bus.in_ready;
  assign w_last_row = w_acc && (r_state == S_MAT) && bus.in_last && (r_done == r_rows - VW'(1));
  assign w_issue    = w_acc && (r_state == S_MAT) && ((r_g_cnt == GW'(K-1)) || w_last_row);

  // Lane view at issue: stored slots, the beat being accepted, then inert lanes.
  always_comb begin
    for (int j = 0; j < K; j++) begin
      w_ln_data[j] = '0;
      w_ln_col[j]  = '0;
      w_ln_last[j] = 1'b0;
      if (GW'(j) < r_g_cnt) begin
        w_ln_data[j] = r_g_data[j];
        w_ln_col[j]  = r_g_col[j];
        w_ln_last[j] = r_g_last[j];
      end else if (GW'(j) == r_g_cnt) begin
        w_ln_data[j] = bus.in_data;
        w_ln_col[j]  = bus.in_col;
        w_ln_last[j] = bus.in_last;
      end
      w_vv[j]   = r_vvalid[w_ln_col[j]] ? r_vec[w_ln_col[j]] : '0;
      w_a[j]    = {{VW{w_ln_data[j][VW-1]}}, w_ln_data[j]};
      w_b[j]    = {{VW{w_vv[j][VW-1]}}, w_vv[j]};
      w_prod[j] = w_a[j] * w_b[j];
    end
  end

  // Results already committed downstream: FIFO contents plus row ends in flight.
  always_comb begin
    w_p_n = '0;
    w_s_n = '0;
    for (int j = 0; j < K; j++) begin
      w_p_n = w_p_n + NW'(r_p_last[j]);
      w_s_n = w_s_n + NW'(r_s_last[j]);
    end
    w_occ = IW'(r_count) + IW'(w_p_n) + IW'(w_s_n);
  end

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_IDLE, S_VEC: w_ready = 1'b1;
      S_MAT:         w_ready = (w_occ <= IW'(DEPTH - K));
      default:       w_ready = 1'b0;
    endcase
  end

  assign bus.in_ready = rst_n & w_ready;

  // Segmented prefix sum: the carry enters lane 0 and each row end resets the run.
  always_comb begin
    w_run = r_carry;
    for (int j = 0; j < K; j++) begin
      w_sum[j] = w_run + {{(AW-PW){r_p_prod[j][PW-1]}}, r_p_prod[j]};
      w_run    = r_p_last[j] ? '0 : w_sum[j];
    end
  end

  // Row ends land in consecutive FIFO slots in lane order.
  always_comb begin
    w_off = '0;
    for (int j = 0; j < K; j++) begin
      w_widx[j] = wrap(IW'(r_wr) + w_off);
      w_off     = w_off + IW'(r_s_last[j]);
    end
  end

  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = bus.out_valid ? r_mem[r_rd] : '0;
  assign w_pop         = bus.out_valid & bus.out_ready;
  assign busy          = (r_state != S_IDLE);
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if ((r_state == S_VEC) && w_acc) r_vec[r_vidx[CW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < K; j++) begin
      if (r_s_last[j]) r_mem[w_widx[j]] <= r_s_sum[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rows    <= '0;
      r_done    <= '0;
      r_cols    <= '0;
      r_vidx    <= '0;
      r_vvalid  <= '0;
      r_g_last  <= '0;
      r_g_cnt   <= '0;
      r_p_valid <= 1'b0;
      r_p_last  <= '0;
      r_s_valid <= 1'b0;
      r_s_last  <= '0;
      r_carry   <= '0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_count   <= '0;
      for (int j = 0; j < K; j++) begin
        r_g_data[j] <= '0;
        r_g_col[j]  <= '0;
        r_p_prod[j] <= '0;
        r_s_sum[j]  <= '0;
      end
    end else begin
      r_p_valid <= w_issue;
      r_p_last  <= w_issue ? w_ln_last : '0;
      for (int j = 0; j < K; j++) begin
        r_p_prod[j] <= w_issue ? w_prod[j] : '0;
        if (r_p_valid) r_s_sum[j] <= w_sum[j];
      end
      r_s_valid <= r_p_valid;
      r_s_last  <= r_p_last;
      if (r_p_valid) r_carry <= w_run;

      r_count <= FW'(IW'(r_count) + w_off - IW'(w_pop));
      r_wr    <= wrap(IW'(r_wr) + w_off);
      if (w_pop) r_rd <= wrap(IW'(r_rd) + IW'(1));

      case (r_state)
        S_IDLE: if (w_acc) begin
          r_rows   <= bus.in_data;
          r_cols   <= {1'b0, bus.in_col} + (CW+1)'(1);
          r_vvalid <= '0;
          r_vidx   <= '0;
          r_state  <= S_VEC;
        end
        S_VEC: if (w_acc) begin
          r_vvalid[r_vidx[CW-1:0]] <= 1'b1;
          if (r_vidx == r_cols - (CW+1)'(1)) begin
            r_g_cnt <= '0;
            r_done  <= '0;
            r_state <= S_MAT;
          end else begin
            r_vidx <= r_vidx + (CW+1)'(1);
          end
        end
        S_MAT: if (w_acc) begin
          if (w_issue) begin
            r_g_cnt  <= '0;
            r_g_last <= '0;
          end else begin
            r_g_data[r_g_cnt] <= bus.in_data;
            r_g_col[r_g_cnt]  <= bus.in_col;
            r_g_last[r_g_cnt] <= bus.in_last;
            r_g_cnt           <= r_g_cnt + GW'(1);
          end
          if (bus.in_last) r_done <= r_done + VW'(1);
          if (w_last_row)  r_state <= S_DRAIN;
        end
        S_DRAIN: if ((r_count == '0) && !r_p_valid && !r_s_valid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
